// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART byte sender between NREQ
//            requesters. One byte is granted at a time. The sender's busy
//            flag is brought into cpu_clk through two flops, and the
//            arbiter re-arbitrates only after the current byte completes.
// Options  : UART_ARB_TIMEOUT_EN - adds a handshake watchdog. It returns the
//            arbiter to IDLE after TIMEOUT_CYC cycles in LOAD/WAIT_DONE and
//            sets the sticky timeout_err flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    cpu_clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic [7:0]              tx_data,
    output logic                    tx_enable,
    input  logic                    tx_status,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int                c_ID_W    = $clog2(NREQ);
    localparam logic [c_ID_W-1:0] c_PTR_RST = c_ID_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_sta_meta;
    logic                r_sta_s;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_ID_W-1:0]   r_grant_id;
    logic [NREQ-1:0]     r_gnt;
    logic [7:0]          r_tx_data;
    logic                w_found;
    logic [c_ID_W-1:0]   w_sel;
    logic [NREQ-1:0]     w_sel_onehot;
    logic [7:0]          w_sel_data;
    logic                w_grant;
`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]         r_cnt;
    logic                r_timeout_err;
    logic                w_cnt_hit;
    logic                w_timeout;
`endif

    // Two-flop synchronizer for the sender's asynchronous busy flag.
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            r_sta_meta <= 1'b0;
            r_sta_s    <= 1'b0;
        end else begin
            r_sta_meta <= tx_status;
            r_sta_s    <= r_sta_meta;
        end
    end

    // Rotating search: indices above ptr first, then wrap to 0..ptr.
    always_comb begin
        w_found      = 1'b0;
        w_sel        = '0;
        w_sel_onehot = '0;
        w_sel_data   = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (i > int'(r_ptr))) begin
                w_found = 1'b1;
                w_sel   = c_ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[i] && (i <= int'(r_ptr))) begin
                w_found = 1'b1;
                w_sel   = c_ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            w_sel_onehot[i] = (w_sel == c_ID_W'(i));
            if (w_sel == c_ID_W'(i)) begin
                w_sel_data = req_data[8*i +: 8];
            end
        end
    end

    // Next-state logic; a stale busy in IDLE holds off the next grant.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_sta_s && w_found) begin
                    w_grant      = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_sta_s) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!r_sta_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        if ((r_state != S_IDLE) && w_cnt_hit) begin
            w_timeout    = 1'b1;
            w_state_next = S_IDLE;
        end
`endif
    end

    // State register plus the grant-time captures (byte, id, pointer).
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= c_PTR_RST;
            r_grant_id <= '0;
            r_gnt      <= '0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_grant ? w_sel_onehot : '0;
            if (w_grant) begin
                r_grant_id <= w_sel;
                r_ptr      <= w_sel;
                r_tx_data  <= w_sel_data;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // The count equals the cycles already spent in LOAD/WAIT_DONE.
    assign w_cnt_hit = (({16'd0, r_cnt} + 32'd1) == 32'(TIMEOUT_CYC));

    // Watchdog counter, cleared on each grant; sticky error flag.
    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            r_cnt         <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_cnt <= 16'd0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // No watchdog: the flag is constant low. The limit is still referenced
    // so both builds share the same parameter set.
    assign timeout_err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

    assign gnt       = r_gnt;
    assign grant_id  = r_grant_id;
    assign tx_data   = r_tx_data;
    assign tx_enable = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART byte sender between up to NREQ requesters (CPU store path, debug dump engine, etc.). It sits in the CPU clock domain between the requesters and the sender's tx_data/tx_enable/tx_status handshake. It grants one byte at a time, drives the byte to the sender, and tracks the sender's busy status through a two-flop synchronizer. It only re-arbitrates once the sender has finished the byte.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 65535, cycle limit for the handshake watchdog (used only when the Configuration macro is defined)

Ports:
- cpu_clk  input  1  the block's single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset; low resets the block immediately, deassertion is released synchronously to cpu_clk
- req  input  NREQ  per-requester request level; requester i holds it high with valid data until it sees gnt[i]
- req_data  input  8*NREQ  packed bytes; requester i occupies [8i+7:8i]
- gnt  output  NREQ  one-hot, one-cycle pulse: the byte of requester i has been captured
- grant_id  output  $clog2(NREQ)  index of the most recent grant
- tx_data  output  8  byte presented to the sender; held stable from grant until the next grant
- tx_enable  output  1  start level to the sender
- tx_status  input  1  sender busy flag, asynchronous to cpu_clk
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  sticky watchdog flag

## Operation
- tx_status passes through a 2-flop synchronizer; the synchronized value is called sta_s.
- Round-robin pointer ptr holds the last granted index. The search for the next grant starts at ptr+1 and wraps modulo NREQ.
- States:
  - IDLE: if sta_s==0 and any req bit is high, select the first active index in rotation order, then:
    - latch tx_data ← req_data[i]
    - pulse gnt[i]
    - set grant_id ← i and ptr ← i
    - go to LOAD
    - If sta_s==1 (stale busy), wait in IDLE.
  - LOAD: tx_enable=1. When sta_s==1, go to WAIT_DONE.
  - WAIT_DONE: tx_enable=0. When sta_s==0, go to IDLE.
- req is ignored outside IDLE. A request withdrawn before it is granted is simply never served; nothing is latched for it.
- On the gnt cycle, a requester drops req or presents its next byte. A req still high after gnt is treated as a new byte.
- Simultaneous requests are served in rotation order, one byte each. No requester is starved: worst-case wait is NREQ-1 bytes.

## Timing
- Reset values:
  - state=IDLE, ptr=NREQ-1 (first priority goes to requester 0)
  - gnt=0, grant_id=0, tx_data=8'h00, tx_enable=0, busy=0, timeout_err=0
  - both synchronizer flops = 0
- Grant latency: req sampled high in IDLE at edge k → gnt, tx_data, grant_id, tx_enable=1 and busy=1 are all visible after edge k (registered outputs).
- Sender busy rise appears on sta_s 2 cycles after tx_status rises. tx_enable drops on the edge after sta_s is seen high.
- Sender done: sta_s falls → IDLE on the next edge. The earliest next grant is the edge after that, so there is a minimum 1-cycle gap in IDLE between bytes.
- Reset asserted mid-byte: tx_enable drops at once and no gnt is issued. The sender shares the same reset and is expected to abort.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to LOAD and runs through LOAD and WAIT_DONE.
  - When it reaches TIMEOUT_CYC: go to IDLE, force tx_enable=0, set timeout_err=1.
  - timeout_err stays set until reset; arbitration continues normally afterwards.
- Not defined:
  - No counter is built; LOAD and WAIT_DONE wait indefinitely.
  - timeout_err is tied to 0.

## Test plan
- After reset release, req=4'b0001, req_data[7:0]=8'h55, sender model raises tx_status 3 cycles after tx_enable and holds it 20 cycles → gnt=4'b0001 for one cycle, tx_data=8'h55, tx_enable high until sta_s=1, busy low again after tx_status falls plus 3 cycles.
- req=4'b1111 held with bytes 8'hA0/A1/A2/A3 for requesters 0..3 → grant order 0,1,2,3,0; each grant only after the previous byte's tx_status has fallen.
- ptr=1 (last grant 1), then req=4'b1001 → requester 3 granted before requester 0.
- tx_status held high across reset release → no grant while sta_s==1; first grant on the cycle after sta_s falls.
- Reset pulled low while in WAIT_DONE → tx_enable=0, busy=0, gnt=0 immediately; after release, requester 0 has first priority.
- With UART_ARB_TIMEOUT_EN defined and TIMEOUT_CYC=16, tx_status never asserted → after 16 cycles in LOAD: tx_enable=0, timeout_err=1, the next pending req is granted. Without the macro: the arbiter stays in LOAD and timeout_err=0.
